// File: rtl/kmem_ctrl_pkg.sv
// Shared types and sizing helpers for the kernel memory controller.
package kmem_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int WORDS_PER_BEAT = DEF_DATA_WIDTH / DEF_WORD_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} kmem_state_e;

  function automatic int calc_beats(input int kernel_size, input int words_per_beat);
    return (kernel_size + words_per_beat - 1) / words_per_beat;
  endfunction

endpackage

// File: rtl/kernel_mem_ctrl_if.sv
// Host load, read command, kernel memory and MAC weight stream bundle.
// KMEM_CTRL_ERR_EN adds the sticky cmd_err status bit.
interface kernel_mem_ctrl_if
  import kmem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int ADDRESS_WIDTH = 6
);
  logic                     load_start;
  logic                     load_valid;
  logic [DATA_WIDTH-1:0]    load_data;
  logic                     load_ready;
  logic                     load_done;
  logic                     read_start;
  logic                     read_done;
  logic                     busy;
  logic                     kernel_loaded;
  logic                     mem_en;
  logic                     mem_write_en;
  logic                     mem_last_address;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_data_in;
  logic [WORD_WIDTH-1:0]    mem_data_out;
  logic [WORD_WIDTH-1:0]    weight_out;
  logic                     weight_valid;
  logic [ADDRESS_WIDTH-1:0] weight_index;
`ifdef KMEM_CTRL_ERR_EN
  logic                     cmd_err;
`endif

  modport slave (
    input  load_start, load_valid, load_data, read_start, mem_data_out,
    output load_ready, load_done, read_done, busy, kernel_loaded,
           mem_en, mem_write_en, mem_last_address, mem_address, mem_data_in,
           weight_out, weight_valid, weight_index
`ifdef KMEM_CTRL_ERR_EN
    , output cmd_err
`endif
  );

  modport master (
    output load_start, load_valid, load_data, read_start, mem_data_out,
    input  load_ready, load_done, read_done, busy, kernel_loaded,
           mem_en, mem_write_en, mem_last_address, mem_address, mem_data_in,
           weight_out, weight_valid, weight_index
`ifdef KMEM_CTRL_ERR_EN
    , input cmd_err
`endif
  );

endinterface

// File: rtl/kmem_rd_pipe.sv
// Delays read tags {valid, index, last} to line up with memory read data.
// READ_LATENCY must be at least 1.
module kmem_rd_pipe #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  input  logic [ADDRESS_WIDTH-1:0] i_idx,
  input  logic                     i_last,
  output logic                     o_vld,
  output logic [ADDRESS_WIDTH-1:0] o_idx,
  output logic                     o_last
);
  logic [READ_LATENCY:1]                    vld_pipe;
  logic [READ_LATENCY:1]                    last_pipe;
  logic [READ_LATENCY:1][ADDRESS_WIDTH-1:0] idx_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      idx_pipe  <= '0;
    end else begin
      vld_pipe[1]  <= i_vld;
      last_pipe[1] <= i_last;
      idx_pipe[1]  <= i_idx;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        last_pipe[s] <= last_pipe[s-1];
        idx_pipe[s]  <= idx_pipe[s-1];
      end
    end
  end

  assign o_vld  = vld_pipe[READ_LATENCY];
  assign o_idx  = idx_pipe[READ_LATENCY];
  assign o_last = last_pipe[READ_LATENCY];

endmodule

// File: rtl/kernel_mem_ctrl.sv
// Kernel memory sequencer: packs host beats into kernel memory and streams weights to the MACs.
// Optional KMEM_CTRL_ERR_EN flags illegal commands on a sticky cmd_err.
module kernel_mem_ctrl
  import kmem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int ADDRESS_WIDTH = 6,
  parameter int KERNEL_SIZE   = 9,
  parameter int READ_LATENCY  = 1
) (
  input logic              clk,
  input logic              rst,
  kernel_mem_ctrl_if.slave bus
);
  localparam int WPB     = DATA_WIDTH / WORD_WIDTH;
  localparam int BEATS   = calc_beats(KERNEL_SIZE, WPB);
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam bit PARTIAL = (KERNEL_SIZE % WPB) != 0;

  kmem_state_e              r_state, w_state_nxt;
  logic [BW-1:0]            r_beat;
  logic                     r_kernel_loaded, r_load_done;
  logic                     r_mem_en, r_mem_write_en, r_mem_last_address;
  logic [ADDRESS_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0]    r_mem_data_in;
  logic                     w_xfer, w_last_beat, w_last_addr, w_issue, w_rd_last, w_rd_start;

  assign w_xfer      = (r_state == LOAD) && bus.load_valid;
  assign w_last_beat = r_beat == BW'(BEATS - 1);
  assign w_last_addr = r_mem_address == ADDRESS_WIDTH'(KERNEL_SIZE - 1);
  assign w_issue     = r_mem_en && !r_mem_write_en;
  assign w_rd_start  = bus.read_start && r_kernel_loaded;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.load_start) w_state_nxt = LOAD;
               else if (w_rd_start) w_state_nxt = READ;
      LOAD:    if (w_xfer && w_last_beat) w_state_nxt = IDLE;
      READ:    if (w_last_addr) w_state_nxt = DRAIN;
      DRAIN:   if (bus.read_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Enables and done pulse default low each cycle; address/data hold between uses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat             <= '0;
      r_kernel_loaded    <= 1'b0;
      r_load_done        <= 1'b0;
      r_mem_en           <= 1'b0;
      r_mem_write_en     <= 1'b0;
      r_mem_last_address <= 1'b0;
      r_mem_address      <= '0;
      r_mem_data_in      <= '0;
    end else begin
      r_load_done    <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_write_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.load_start) begin
            r_kernel_loaded <= 1'b0;
            r_beat          <= '0;
          end else if (w_rd_start) begin
            r_mem_en      <= 1'b1;
            r_mem_address <= '0;
          end
        end
        LOAD: begin
          if (w_xfer) begin
            r_mem_en           <= 1'b1;
            r_mem_write_en     <= 1'b1;
            r_mem_address      <= ADDRESS_WIDTH'(int'(r_beat) * WPB);
            r_mem_data_in      <= bus.load_data;
            r_mem_last_address <= !(w_last_beat && PARTIAL);
            if (w_last_beat) begin
              r_load_done     <= 1'b1;
              r_kernel_loaded <= 1'b1;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        READ: begin
          if (!w_last_addr) begin
            r_mem_en      <= 1'b1;
            r_mem_address <= r_mem_address + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  kmem_rd_pipe #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_issue),
    .i_idx (r_mem_address),
    .i_last(w_issue && w_last_addr),
    .o_vld (bus.weight_valid),
    .o_idx (bus.weight_index),
    .o_last(w_rd_last)
  );

  assign bus.read_done        = bus.weight_valid && w_rd_last;
  assign bus.load_ready       = r_state == LOAD;
  assign bus.busy             = r_state != IDLE;
  assign bus.load_done        = r_load_done;
  assign bus.kernel_loaded    = r_kernel_loaded;
  assign bus.mem_en           = r_mem_en;
  assign bus.mem_write_en     = r_mem_write_en;
  assign bus.mem_last_address = r_mem_last_address;
  assign bus.mem_address      = r_mem_address;
  assign bus.mem_data_in      = r_mem_data_in;
  assign bus.weight_out       = bus.mem_data_out;

`ifdef KMEM_CTRL_ERR_EN
  logic r_cmd_err, w_err;

  // A read request is only an error when no load request claims the same cycle.
  assign w_err = ((r_state == IDLE) && bus.read_start && !bus.load_start && !r_kernel_loaded)
              || ((r_state != IDLE) && (bus.load_start || bus.read_start))
              || ((r_state != LOAD) && bus.load_valid);

  always_ff @(posedge clk) begin
    if (rst)        r_cmd_err <= 1'b0;
    else if (w_err) r_cmd_err <= 1'b1;
  end

  assign bus.cmd_err = r_cmd_err;
`endif

endmodule

// File: tb/tb_kernel_mem_ctrl.sv
// Directed bench for kernel_mem_ctrl: KERNEL_SIZE=9 main instance plus a KERNEL_SIZE=8 shadow.
module tb_kernel_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  kernel_mem_ctrl_if #(.DATA_WIDTH(128), .WORD_WIDTH(32), .ADDRESS_WIDTH(6)) b9 ();
  kernel_mem_ctrl_if #(.DATA_WIDTH(128), .WORD_WIDTH(32), .ADDRESS_WIDTH(6)) b8 ();

  kernel_mem_ctrl #(.DATA_WIDTH(128), .WORD_WIDTH(32), .ADDRESS_WIDTH(6),
                    .KERNEL_SIZE(9), .READ_LATENCY(1))
    u_dut9 (.clk(clk), .rst(rst), .bus(b9));

  kernel_mem_ctrl #(.DATA_WIDTH(128), .WORD_WIDTH(32), .ADDRESS_WIDTH(6),
                    .KERNEL_SIZE(8), .READ_LATENCY(1))
    u_dut8 (.clk(clk), .rst(rst), .bus(b8));

  assign b8.load_start   = b9.load_start;
  assign b8.load_valid   = b9.load_valid;
  assign b8.load_data    = b9.load_data;
  assign b8.read_start   = b9.read_start;
  assign b8.mem_data_out = '0;

  // Kernel memory model: 1-cycle read latency, partial final beat writes lane 0 only (9 % 4).
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (b9.mem_en && b9.mem_write_en)
      for (int l = 0; l < 4; l++)
        if (b9.mem_last_address || l < 1)
          mem[int'(b9.mem_address) + l] <= b9.mem_data_in[l*32 +: 32];
    if (b9.mem_en && !b9.mem_write_en)
      b9.mem_data_out <= mem[int'(b9.mem_address)];
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_beat(input logic [31:0] base, input int b);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = base + 32'(4*b + l);
    return r;
  endfunction

  task automatic do_load(input logic [31:0] base, input logic [7:0] pat, input int ncyc,
                         input bit prio, input bit k8);
    int b = 0;
    b9.load_start = 1'b1;
    b9.read_start = prio;
    @(negedge clk);
    b9.load_start = 1'b0;
    b9.read_start = 1'b0;
    chk("ld_ready", b9.load_ready, 1'b1);
    chk("ld_kl_clr", b9.kernel_loaded, 1'b0);
    chk("ld_no_rd", b9.mem_en, 1'b0);
    for (int c = 0; c < ncyc; c++) begin
      b9.load_valid = pat[c];
      b9.load_data  = mk_beat(base, b);
      @(negedge clk);
      chk("ld_en", b9.mem_en, pat[c]);
      if (pat[c]) begin
        chk("ld_we", b9.mem_write_en, 1'b1);
        chk("ld_addr", b9.mem_address, 6'(4*b));
        chk("ld_data", b9.mem_data_in, mk_beat(base, b));
        chk("ld_last", b9.mem_last_address, b != 2);
        chk("ld_done", b9.load_done, b == 2);
        chk("ld_kl", b9.kernel_loaded, b == 2);
        if (b == 2) chk("ld_rdy_drop", b9.load_ready, 1'b0);
        b++;
      end
      if (k8) begin
        chk("k8_en", b8.mem_en, c < 2);
        if (c < 2) begin
          chk("k8_last", b8.mem_last_address, 1'b1);
          chk("k8_addr", b8.mem_address, 6'(4*c));
          chk("k8_done", b8.load_done, c == 1);
        end
      end
    end
    b9.load_valid = 1'b0;
    chk("ld_nwr", b, 3);
    @(negedge clk);
    chk("ld_done_pulse", b9.load_done, 1'b0);
    chk("ld_idle", b9.busy, 1'b0);
    chk("ld_kl_hold", b9.kernel_loaded, 1'b1);
  endtask

  task automatic rd_stream(input logic [31:0] base, input bit inject);
    b9.read_start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      b9.read_start = 1'b0;
      if (inject) b9.load_start = (k == 3);
      if (k <= 9) begin
        chk("rd_en", b9.mem_en, 1'b1);
        chk("rd_we", b9.mem_write_en, 1'b0);
        chk("rd_addr", b9.mem_address, 6'(k - 1));
      end
      if (k == 10) chk("rd_en_drain", b9.mem_en, 1'b0);
      if (k >= 2 && k <= 10) begin
        chk("rd_vld", b9.weight_valid, 1'b1);
        chk("rd_idx", b9.weight_index, 6'(k - 2));
        chk("rd_wt", b9.weight_out, base + 32'(k - 2));
        chk("rd_done", b9.read_done, k == 10);
      end
      if (k == 1) chk("rd_vld0", b9.weight_valid, 1'b0);
      if (k == 4) chk("rd_inj_rdy", b9.load_ready, 1'b0);
      if (k == 11) begin
        chk("rd_busy_end", b9.busy, 1'b0);
        chk("rd_vld_end", b9.weight_valid, 1'b0);
        chk("rd_kl_keep", b9.kernel_loaded, 1'b1);
      end
    end
  endtask

  initial begin
    bit hit = 1'b0;
    b9.load_start = 1'b0;
    b9.load_valid = 1'b0;
    b9.load_data  = '0;
    b9.read_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", b9.busy, 1'b0);
    chk("rst_kl", b9.kernel_loaded, 1'b0);
    chk("rst_en", b9.mem_en, 1'b0);
    chk("rst_addr", b9.mem_address, 6'd0);
    chk("rst_last", b9.mem_last_address, 1'b0);
    chk("rst_rdy", b9.load_ready, 1'b0);
    chk("rst_vld", b9.weight_valid, 1'b0);
    rst = 1'b0;

    // read request with no kernel resident
    b9.read_start = 1'b1;
    @(negedge clk);
    b9.read_start = 1'b0;
    chk("ill_busy", b9.busy, 1'b0);
    chk("ill_en", b9.mem_en, 1'b0);
    @(negedge clk);
    chk("ill_en2", b9.mem_en, 1'b0);
    chk("ill_vld", b9.weight_valid, 1'b0);
`ifdef KMEM_CTRL_ERR_EN
    chk("ill_err", b9.cmd_err, 1'b1);
`endif

    do_load(32'hA000_0000, 8'b111, 3, 1'b0, 1'b1);
    rd_stream(32'hA000_0000, 1'b1);

    // priority plus gapped load, then readback
    do_load(32'hB000_0100, 8'b10101, 5, 1'b1, 1'b0);
    rd_stream(32'hB000_0100, 1'b0);

    // reset in the middle of a read
    b9.read_start = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      b9.read_start = 1'b0;
      if (b9.weight_valid && b9.weight_index == 6'd4) hit = 1'b1;
    end
    chk("mrst_reach", hit, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_en", b9.mem_en, 1'b0);
    chk("mrst_addr", b9.mem_address, 6'd0);
    chk("mrst_data", b9.mem_data_in, 128'd0);
    chk("mrst_vld", b9.weight_valid, 1'b0);
    chk("mrst_idx", b9.weight_index, 6'd0);
    chk("mrst_done", b9.read_done, 1'b0);
    chk("mrst_busy", b9.busy, 1'b0);
    chk("mrst_kl", b9.kernel_loaded, 1'b0);
    b9.read_start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      b9.read_start = 1'b0;
      chk("mrst_ign_en", b9.mem_en, 1'b0);
      chk("mrst_ign_done", b9.read_done, 1'b0);
      chk("mrst_ign_busy", b9.busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
